// File: rtl/alu_rr_sched.sv
// alu_rr_sched: round-robin scheduler sharing one registered ALU among NREQ valid/ready requesters.
// Optional feature macro ALU_SCHED_PRIO0_EN: requester 0 gets absolute priority over the round-robin.
module alu_rr_sched #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned W       = 4,
    parameter int unsigned OPW     = 3,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*OPW-1:0] req_opcode,
    input  logic [NREQ*W-1:0]   req_op1,
    input  logic [NREQ*W-1:0]   req_op2,
    output logic [NREQ-1:0]     rsp_valid,
    input  logic [NREQ-1:0]     rsp_ready,
    output logic [W-1:0]        rsp_data,
    output logic [OPW-1:0]      alu_opcode,
    output logic [W-1:0]        alu_op1,
    output logic [W-1:0]        alu_op2,
    input  logic [W-1:0]        alu_result
);

    localparam int unsigned GW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(ALU_LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [W-1:0]    rsp_data_q, rsp_data_d;
    logic [OPW-1:0]  alu_opcode_q, alu_opcode_d;
    logic [W-1:0]    alu_op1_q, alu_op1_d;
    logic [W-1:0]    alu_op2_q, alu_op2_d;

    logic            gnt_found;
    logic [GW-1:0]   gnt_idx;

    // First valid requester after ptr, wrapping; optionally skipping requester 0.
    function automatic logic [GW:0] rr_pick(input logic [NREQ-1:0] valid,
                                            input logic [GW-1:0]   ptr,
                                            input logic            skip0);
        logic [GW:0] res;
        int unsigned idx;
        res = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(ptr) + k) % NREQ;
            if (!res[GW] && valid[GW'(idx)] && !(skip0 && (idx == 0))) begin
                res = {1'b1, GW'(idx)};
            end
        end
        return res;
    endfunction

    always_comb begin
`ifdef ALU_SCHED_PRIO0_EN
        if (req_valid[0]) begin
            {gnt_found, gnt_idx} = {1'b1, GW'(0)};
        end else begin
            {gnt_found, gnt_idx} = rr_pick(req_valid, ptr_q, 1'b1);
        end
`else
        {gnt_found, gnt_idx} = rr_pick(req_valid, ptr_q, 1'b0);
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            grant_q      <= '0;
            ptr_q        <= GW'(NREQ - 1);
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            alu_opcode_q <= '0;
            alu_op1_q    <= '0;
            alu_op2_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            ptr_q        <= ptr_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            alu_opcode_q <= alu_opcode_d;
            alu_op1_q    <= alu_op1_d;
            alu_op2_q    <= alu_op2_d;
        end
    end

    // Next-state: accept in IDLE, wait out the ALU latency in EXEC, hold the response in RESP.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        ptr_d        = ptr_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        alu_opcode_d = alu_opcode_q;
        alu_op1_d    = alu_op1_q;
        alu_op2_d    = alu_op2_q;
        req_ready    = '0;

        unique case (state_q)
            IDLE: begin
                if (gnt_found && rstn) begin
                    req_ready[gnt_idx] = 1'b1;
                    grant_d            = gnt_idx;
                    alu_opcode_d       = req_opcode[gnt_idx*OPW +: OPW];
                    alu_op1_d          = req_op1[gnt_idx*W +: W];
                    alu_op2_d          = req_op2[gnt_idx*W +: W];
                    cnt_d              = CW'(ALU_LAT);
                    state_d            = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    rsp_data_d           = alu_result;
                    rsp_valid_d          = '0;
                    rsp_valid_d[grant_q] = 1'b1;
                    state_d              = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                if (rsp_ready[grant_q]) begin
                    rsp_valid_d = '0;
`ifdef ALU_SCHED_PRIO0_EN
                    if (grant_q != '0) begin
                        ptr_d = grant_q;
                    end
`else
                    ptr_d = grant_q;
`endif
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign alu_opcode = alu_opcode_q;
    assign alu_op1    = alu_op1_q;
    assign alu_op2    = alu_op2_q;

endmodule

// File: tb/tb_alu_rr_sched.sv
// Scoreboard bench for alu_rr_sched: transaction-level reference model predicts grants and results,
// a separate monitor checks every response the DUT presents.
module tb_alu_rr_sched;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned W       = 4;
    localparam int unsigned OPW     = 3;
    localparam int unsigned ALU_LAT = 1;
    localparam int unsigned GW      = $clog2(NREQ);

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*OPW-1:0] req_opcode;
    logic [NREQ*W-1:0]   req_op1;
    logic [NREQ*W-1:0]   req_op2;
    logic [NREQ-1:0]     rsp_valid;
    logic [NREQ-1:0]     rsp_ready;
    logic [W-1:0]        rsp_data;
    logic [OPW-1:0]      alu_opcode;
    logic [W-1:0]        alu_op1;
    logic [W-1:0]        alu_op2;
    logic [W-1:0]        alu_result = '0;

    alu_rr_sched #(.NREQ(NREQ), .W(W), .OPW(OPW), .ALU_LAT(ALU_LAT)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .req_op1    (req_op1),
        .req_op2    (req_op2),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .alu_opcode (alu_opcode),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_result (alu_result)
    );

    always #5 clk = ~clk;

    // Registered adder standing in for the ALU (latency 1, result mod 16).
    always @(posedge clk) alu_result <= W'(alu_op1 + alu_op2);

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [GW-1:0] g;
        logic [W-1:0]  data;
        int unsigned   due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    // Stimulus state: one pending request per requester, held until the model accepts it.
    logic            pend [NREQ];
    logic [OPW-1:0]  p_op [NREQ];
    logic [W-1:0]    p_a  [NREQ];
    logic [W-1:0]    p_b  [NREQ];
    logic [NREQ-1:0] gen_mask;
    int unsigned     gen_pct, wd_pct, rr_pct, rr_hold;

    // Reference model state.
    logic            m_idle;
    logic [GW-1:0]   m_ptr, m_g;
    int unsigned     m_due;
    logic [OPW-1:0]  m_op;
    logic [W-1:0]    m_a, m_b;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    // Grant rule: first valid requester after the last-served one, wrapping.
    function automatic int pick(input logic [NREQ-1:0] v, input logic [GW-1:0] ptr);
        int unsigned i;
`ifdef ALU_SCHED_PRIO0_EN
        if (v[0]) return 0;
`endif
        for (int unsigned k = 1; k <= NREQ; k++) begin
            i = (32'(ptr) + k) % NREQ;
`ifdef ALU_SCHED_PRIO0_EN
            if (i == 0) continue;
`endif
            if (v[GW'(i)]) return int'(i);
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_idle = 1'b1;
        m_ptr  = GW'(NREQ - 1);
        m_g    = '0;
        m_due  = 0;
        m_op   = '0;
        m_a    = '0;
        m_b    = '0;
        sb.delete();
    endtask

    task automatic drive_inputs(output logic [NREQ-1:0] v, output logic [NREQ-1:0] r);
        for (int i = 0; i < NREQ; i++) begin
            if (gen_mask[i] && !pend[i] && ($urandom_range(99) < gen_pct)) begin
                pend[i] = 1'b1;
                p_op[i] = OPW'($urandom);
                p_a[i]  = W'($urandom);
                p_b[i]  = W'($urandom);
            end else if (pend[i] && ($urandom_range(99) < wd_pct)) begin
                pend[i] = 1'b0;
            end
            v[i] = pend[i];
            r[i] = (rr_hold == 0) && ($urandom_range(99) < rr_pct);
            req_opcode[i*OPW +: OPW] = p_op[i];
            req_op1[i*W +: W]        = p_a[i];
            req_op2[i*W +: W]        = p_b[i];
        end
        if (rr_hold > 0) rr_hold--;
        req_valid = v;
        rsp_ready = r;
    endtask

    // One clock of stimulus plus model prediction of req_ready and the ALU operand outputs.
    task automatic step();
        logic [NREQ-1:0] v, r, exp_rdy;
        logic            acc, hs;
        logic [GW-1:0]   gi;
        int              g;
        int unsigned     n;
        @(posedge clk);
        #1;
        n = cyc;
        drive_inputs(v, r);
        exp_rdy = '0;
        acc = 1'b0;
        hs  = 1'b0;
        gi  = '0;
        if (m_idle) begin
            g = pick(v, m_ptr);
            if (g >= 0) begin
                gi      = GW'(g);
                exp_rdy = NREQ'(1) << gi;
                acc     = 1'b1;
            end
        end else if ((n >= m_due) && r[m_g]) begin
            hs = 1'b1;
        end
        @(negedge clk);
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("alu_opcode", 32'(alu_opcode), 32'(m_op));
        chk("alu_op1", 32'(alu_op1), 32'(m_a));
        chk("alu_op2", 32'(alu_op2), 32'(m_b));
        if (acc) begin
            sb.push_back('{g: gi, data: W'(p_a[gi] + p_b[gi]), due: n + ALU_LAT + 2});
            m_idle   = 1'b0;
            m_g      = gi;
            m_due    = n + ALU_LAT + 2;
            m_op     = p_op[gi];
            m_a      = p_a[gi];
            m_b      = p_b[gi];
            pend[gi] = 1'b0;
        end
        if (hs) begin
            m_idle = 1'b1;
`ifdef ALU_SCHED_PRIO0_EN
            if (m_g != '0) m_ptr = m_g;
`else
            m_ptr = m_g;
`endif
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_req_ready", 32'(req_ready), 32'(0));
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_rsp_data", 32'(rsp_data), 32'(0));
        chk("rst_alu_opcode", 32'(alu_opcode), 32'(0));
        chk("rst_alu_op1", 32'(alu_op1), 32'(0));
        chk("rst_alu_op2", 32'(alu_op2), 32'(0));
    endtask

    // Response monitor: pops the scoreboard on each new response and checks it is held until accepted.
    logic          resp_seen = 1'b0;
    logic [GW-1:0] cur_g = '0;
    logic [W-1:0]  cur_data = '0;
    exp_t          e;

    always @(negedge clk) begin
        if (!rstn) begin
            resp_seen = 1'b0;
        end else begin
            if (resp_seen) begin
                chk("rsp_valid_hold", 32'(rsp_valid), 32'(NREQ'(1) << cur_g));
                chk("rsp_data_hold", 32'(rsp_data), 32'(cur_data));
            end else if (rsp_valid != '0) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_unexpected @cyc %0d: rsp_valid=%b with nothing outstanding", cyc, rsp_valid);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_valid", 32'(rsp_valid), 32'(NREQ'(1) << e.g));
                    chk("rsp_data", 32'(rsp_data), 32'(e.data));
                    chk("rsp_cycle", cyc, e.due);
                    cur_g     = e.g;
                    cur_data  = e.data;
                    resp_seen = 1'b1;
                end
            end
            if (resp_seen && rsp_ready[cur_g]) resp_seen = 1'b0;
        end
    end

    initial begin
        req_valid  = '0;
        rsp_ready  = '0;
        req_opcode = '0;
        req_op1    = '0;
        req_op2    = '0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0;
            p_op[i] = '0;
            p_a[i]  = '0;
            p_b[i]  = '0;
        end
        gen_mask = '0;
        gen_pct  = 0;
        wd_pct   = 0;
        rr_pct   = 100;
        rr_hold  = 0;
        model_reset();

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1 rstn = 1'b1;

        // Single request from requester 1: 10 + 10 -> 4, response three cycles after accept.
        pend[1] = 1'b1;
        p_op[1] = 3'b000;
        p_a[1]  = 4'b1010;
        p_b[1]  = 4'b1010;
        repeat (8) step();

        // All requesters continuously valid, responses accepted at once.
        gen_mask = '1;
        gen_pct  = 100;
        repeat (24) step();
        gen_mask = '0;
        repeat (20) step();

        // Backpressure on requester 2's response with another requester waiting.
        pend[2] = 1'b1;
        p_op[2] = 3'b101;
        p_a[2]  = 4'h7;
        p_b[2]  = 4'h5;
        rr_hold = 8;
        repeat (3) step();
        pend[0] = 1'b1;
        p_a[0]  = 4'hF;
        p_b[0]  = 4'h3;
        repeat (14) step();

        // Reset in the middle of EXEC, with every request line high during reset.
        pend[1] = 1'b1;
        p_a[1]  = 4'h6;
        p_b[1]  = 4'h9;
        repeat (2) step();
        @(posedge clk);
        #1;
        rstn      = 1'b0;
        req_valid = '1;
        #1;
        check_reset_outputs();
        model_reset();
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        req_valid = '0;
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1 rstn = 1'b1;
        pend[0] = 1'b1;
        pend[2] = 1'b1;
        p_a[0]  = 4'h1;
        p_b[0]  = 4'h2;
        repeat (14) step();

        // Requesters 0 and 3 continuously valid.
        gen_mask = NREQ'(4'b1001);
        gen_pct  = 100;
        repeat (24) step();
        gen_mask = '0;
        repeat (12) step();

        // Random traffic with withdrawals and random response backpressure.
        gen_mask = '1;
        gen_pct  = 35;
        wd_pct   = 8;
        rr_pct   = 60;
        repeat (800) step();
        gen_mask = '0;
        wd_pct   = 0;
        rr_pct   = 100;
        repeat (40) step();

        chk("sb_drained", 32'(sb.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
